// File: rtl/risc_ctrl_seq_if.sv
// -----------------------------------------------------------------------------
// risc_ctrl_seq_if
// Bundles the sequencer's instruction-fetch handshake and its datapath control
// into one interface.
//   master : the sequencer. Drives the fetch request/address, the PC, ALU and
//            register-file control, the halted flag and the retired count.
//            Receives the instruction word, the fetch valid and the ALU zero flag.
//   slave  : the instruction memory / datapath side (the opposite directions).
// Parameter AW : width of the PC and the fetch address.
// -----------------------------------------------------------------------------
interface risc_ctrl_seq_if #(
  parameter int AW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          imem_valid;
  logic          alu_zero;
  logic [AW-1:0] pc_out;
  logic [2:0]    alu_op;
  logic [2:0]    rf_raddr1;
  logic [2:0]    rf_raddr2;
  logic [2:0]    rf_waddr;
  logic          rf_we;
  logic          halted;
  logic [31:0]   instr_count;

  modport master (
    output imem_req, imem_addr, pc_out, alu_op, rf_raddr1, rf_raddr2,
           rf_waddr, rf_we, halted, instr_count,
    input  imem_rdata, imem_valid, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, pc_out, alu_op, rf_raddr1, rf_raddr2,
           rf_waddr, rf_we, halted, instr_count,
    output imem_rdata, imem_valid, alu_zero
  );
endinterface

// File: rtl/risc_ctrl_seq.sv
// -----------------------------------------------------------------------------
// risc_ctrl_seq
// Multi-cycle control sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB, looping
// back to FETCH, or parking in HALT. Fetches 16-bit instructions over a
// request/valid handshake that may insert wait states, then drives register
// file and ALU control for an external datapath. Supports ALU register ops,
// BEQ, JMP, HALT and NOPs.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : risc_ctrl_seq_if.master (fetch handshake, PC, ALU/RF control,
//            halted, instr_count)
// Parameters:
//   AW       : PC / fetch-address width (4..32)
//   RESET_PC : PC loaded on reset
// Optional feature:
//   RISC_CTRL_PERF_EN : when defined, instr_count counts WB cycles (HALT
//                       included); otherwise instr_count is tied to zero.
// -----------------------------------------------------------------------------
module risc_ctrl_seq #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  risc_ctrl_seq_if.master  bus
);

  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd10;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [15:0]   ir_r;
  logic          zero_r;
  logic [AW-1:0] pc_r;
  logic [AW-1:0] pc_next_s;
  logic [AW-1:0] imm6_s;
  logic [AW-1:0] imm12_s;
  logic [3:0]    opcode_s;
  logic          imem_req_r;
  logic [2:0]    alu_op_r;
  logic [2:0]    alu_op_s;
  logic          rf_we_r;
  logic          rf_we_s;
  logic          halted_r;
  logic [2:0]    raddr1_r;
  logic [2:0]    raddr2_r;
  logic [2:0]    waddr_r;

  assign opcode_s = ir_r[15:12];

  // Next-state logic of the instruction sequencing FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_valid) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: state_s = ST_EXEC;
      ST_EXEC:   state_s = ST_WB;
      ST_WB: begin
        if (opcode_s == OP_HALT) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HALT:   state_s = ST_HALT;
      default:   state_s = ST_IDLE;
    endcase
  end

  // ALU op and RF write enable for the state being entered; they are
  // registered so the outputs come straight from flops.
  always_comb begin
    alu_op_s = 3'd0;
    rf_we_s  = 1'b0;
    if (state_s == ST_EXEC) begin
      if (opcode_s[3] == 1'b0) begin
        alu_op_s = opcode_s[2:0];
      end else if (opcode_s == OP_BEQ) begin
        alu_op_s = ALU_SUB;
      end else begin
        alu_op_s = 3'd0;
      end
    end else if (state_s == ST_WB) begin
      rf_we_s = (opcode_s[3] == 1'b0);
    end else begin
      alu_op_s = 3'd0;
      rf_we_s  = 1'b0;
    end
  end

  // PC update applied at the end of WB; the casts sign-extend imm6 and
  // zero-extend imm12 to AW bits, wrapping everything modulo 2^AW.
  always_comb begin
    imm6_s    = AW'($signed(ir_r[5:0]));
    imm12_s   = AW'(ir_r[11:0]);
    pc_next_s = pc_r + AW'(1'b1);
    if (opcode_s == OP_JMP) begin
      pc_next_s = imm12_s;
    end else if ((opcode_s == OP_BEQ) && zero_r) begin
      pc_next_s = pc_r + AW'(1'b1) + imm6_s;
    end else if (opcode_s == OP_HALT) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_r + AW'(1'b1);
    end
  end

  // State register and the state-decoded control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      imem_req_r <= 1'b0;
      halted_r   <= 1'b0;
      alu_op_r   <= 3'd0;
      rf_we_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      imem_req_r <= (state_s == ST_FETCH);
      halted_r   <= (state_s == ST_HALT);
      alu_op_r   <= alu_op_s;
      rf_we_r    <= rf_we_s;
    end
  end

  // Instruction register (accepting FETCH edge only) and the zero flag
  // captured at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r   <= 16'd0;
      zero_r <= 1'b0;
    end else begin
      if ((state_r == ST_FETCH) && bus.imem_valid) begin
        ir_r <= bus.imem_rdata;
      end
      if (state_r == ST_EXEC) begin
        zero_r <= bus.alu_zero;
      end
    end
  end

  // Register-file addresses: loaded leaving DECODE, cleared on entry to HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr1_r <= 3'd0;
      raddr2_r <= 3'd0;
      waddr_r  <= 3'd0;
    end else if (state_r == ST_DECODE) begin
      raddr1_r <= ir_r[8:6];
      raddr2_r <= ir_r[5:3];
      waddr_r  <= ir_r[11:9];
    end else if (state_s == ST_HALT) begin
      raddr1_r <= 3'd0;
      raddr2_r <= 3'd0;
      waddr_r  <= 3'd0;
    end
  end

  // Program counter, updated once per instruction at the end of WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (state_r == ST_WB) begin
      pc_r <= pc_next_s;
    end
  end

`ifdef RISC_CTRL_PERF_EN
  logic [31:0] count_r;

  // Retired-instruction counter: one per WB cycle, wraps at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
    end else if (state_r == ST_WB) begin
      count_r <= count_r + 32'd1;
    end
  end

  assign bus.instr_count = count_r;
`else
  assign bus.instr_count = 32'd0;
`endif

  assign bus.imem_req  = imem_req_r;
  assign bus.imem_addr = pc_r;
  assign bus.pc_out    = pc_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.rf_raddr1 = raddr1_r;
  assign bus.rf_raddr2 = raddr2_r;
  assign bus.rf_waddr  = waddr_r;
  assign bus.rf_we     = rf_we_r;
  assign bus.halted    = halted_r;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_risc_ctrl_seq
// Two sequencers (AW=16 and AW=4) driven by a fetch responder with random wait
// states. Expected per-instruction behaviour is pushed into a queue when an
// instruction is handed over; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_risc_ctrl_seq;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] next;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [2:0]  rd;
    logic [2:0]  aluop;
    logic        we;
    logic        halt;
  } exp_t;

  logic clk;
  int   nchk;
  int   nerr;

  logic        rst_v   [2];
  logic        i_valid [2];
  logic [15:0] i_rdata [2];
  logic        i_zero  [2];

  logic        o_req  [2];
  logic [31:0] o_addr [2];
  logic [31:0] o_pc   [2];
  logic [31:0] o_cnt  [2];
  logic [2:0]  o_op   [2];
  logic [2:0]  o_r1   [2];
  logic [2:0]  o_r2   [2];
  logic [2:0]  o_wa   [2];
  logic        o_we   [2];
  logic        o_halt [2];

  exp_t   expq [2][$];
  exp_t   cur  [2];
  int     ph   [2];
  int     rel  [2];
  int     nret [2];
  longint m_pc [2];

  risc_ctrl_seq_if #(.AW(16)) b0 ();
  risc_ctrl_seq_if #(.AW(4))  b1 ();

  risc_ctrl_seq #(.AW(16), .RESET_PC(16'd0)) dut0 (.clk(clk), .rst_n(rst_v[0]), .bus(b0));
  risc_ctrl_seq #(.AW(4),  .RESET_PC(4'd0))  dut1 (.clk(clk), .rst_n(rst_v[1]), .bus(b1));

  assign b0.imem_valid = i_valid[0];
  assign b0.imem_rdata = i_rdata[0];
  assign b0.alu_zero   = i_zero[0];
  assign b1.imem_valid = i_valid[1];
  assign b1.imem_rdata = i_rdata[1];
  assign b1.alu_zero   = i_zero[1];

  assign o_req[0]  = b0.imem_req;
  assign o_addr[0] = {16'd0, b0.imem_addr};
  assign o_pc[0]   = {16'd0, b0.pc_out};
  assign o_cnt[0]  = b0.instr_count;
  assign o_op[0]   = b0.alu_op;
  assign o_r1[0]   = b0.rf_raddr1;
  assign o_r2[0]   = b0.rf_raddr2;
  assign o_wa[0]   = b0.rf_waddr;
  assign o_we[0]   = b0.rf_we;
  assign o_halt[0] = b0.halted;
  assign o_req[1]  = b1.imem_req;
  assign o_addr[1] = {28'd0, b1.imem_addr};
  assign o_pc[1]   = {28'd0, b1.pc_out};
  assign o_cnt[1]  = b1.instr_count;
  assign o_op[1]   = b1.alu_op;
  assign o_r1[1]   = b1.rf_raddr1;
  assign o_r2[1]   = b1.rf_raddr2;
  assign o_wa[1]   = b1.rf_waddr;
  assign o_we[1]   = b1.rf_we;
  assign o_halt[1] = b1.halted;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference behaviour of one instruction, straight from the ISA rules.
  function automatic exp_t model(input longint pc, input int aw, input logic [15:0] ins, input logic z);
    exp_t   e;
    int     op;
    longint m;
    longint s;
    op      = int'(ins[15:12]);
    m       = longint'(1) << aw;
    e.pc    = 32'(pc);
    e.r1    = ins[8:6];
    e.r2    = ins[5:3];
    e.rd    = ins[11:9];
    e.aluop = (op < 8) ? 3'(op) : ((op == 8) ? 3'd1 : 3'd0);
    e.we    = (op < 8);
    e.halt  = (op == 10);
    s       = longint'(ins[5:0]);
    if (s >= 32) s = s - 64;
    if (op == 9)                 e.next = 32'(longint'(ins[11:0]) % m);
    else if (op == 8 && z)       e.next = 32'((((pc + 1 + s) % m) + m) % m);
    else if (op == 10)           e.next = 32'(pc);
    else                         e.next = 32'((pc + 1) % m);
    return e;
  endfunction

  // Monitor for one DUT, evaluated every falling edge.
  task automatic mon(input int d);
    logic [31:0] ecnt;
    if (!rst_v[d]) begin
      ph[d]   = 0;
      rel[d]  = 0;
      nret[d] = 0;
      chk("rst_ctrl", d, {26'd0, o_req[d], o_op[d], o_we[d], o_halt[d]}, 32'd0);
      chk("rst_rfaddr", d, {23'd0, o_r1[d], o_r2[d], o_wa[d]}, 32'd0);
      chk("rst_pc", d, o_pc[d], 32'd0);
      chk("rst_count", d, o_cnt[d], 32'd0);
      return;
    end
    if (rel[d] < 3) rel[d]++;
    if (rel[d] == 1) chk("start_req_idle", d, {31'd0, o_req[d]}, 32'd0);
    if (rel[d] == 2) begin
      chk("start_req", d, {31'd0, o_req[d]}, 32'd1);
      chk("start_addr", d, o_addr[d], 32'd0);
    end
`ifdef RISC_CTRL_PERF_EN
    ecnt = 32'(nret[d]);
`else
    ecnt = 32'd0;
`endif
    case (ph[d])
      0: chk("fetch_ctrl", d, {27'd0, o_op[d], o_we[d], o_halt[d]}, 32'd0);
      1: begin
        chk("decode_ctrl", d, {26'd0, o_req[d], o_op[d], o_we[d], o_halt[d]}, 32'd0);
        ph[d] = 2;
      end
      2: begin
        chk("exec_alu_op", d, {29'd0, o_op[d]}, {29'd0, cur[d].aluop});
        chk("exec_raddr", d, {26'd0, o_r1[d], o_r2[d]}, {26'd0, cur[d].r1, cur[d].r2});
        chk("exec_req_we", d, {30'd0, o_req[d], o_we[d]}, 32'd0);
        ph[d] = 3;
      end
      3: begin
        chk("wb_we", d, {31'd0, o_we[d]}, {31'd0, cur[d].we});
        chk("wb_waddr", d, {29'd0, o_wa[d]}, {29'd0, cur[d].rd});
        chk("wb_req_op", d, {28'd0, o_req[d], o_op[d]}, 32'd0);
        nret[d]++;
        ph[d] = 4;
      end
      4: begin
        chk("count", d, o_cnt[d], ecnt);
        chk("we_pulse", d, {31'd0, o_we[d]}, 32'd0);
        if (cur[d].halt) begin
          chk("halt_flag", d, {31'd0, o_halt[d]}, 32'd1);
          chk("halt_req", d, {31'd0, o_req[d]}, 32'd0);
          chk("halt_pc", d, o_pc[d], cur[d].pc);
          ph[d] = 5;
        end else begin
          chk("next_req", d, {30'd0, o_req[d], o_halt[d]}, 32'd2);
          chk("next_pc", d, o_addr[d], cur[d].next);
          ph[d] = 0;
        end
      end
      5: begin
        chk("halted_ctrl", d, {26'd0, o_req[d], o_op[d], o_we[d], o_halt[d]}, 32'd1);
        chk("halted_rfaddr", d, {23'd0, o_r1[d], o_r2[d], o_wa[d]}, 32'd0);
        chk("halted_pc", d, o_pc[d], cur[d].pc);
        chk("halted_count", d, o_cnt[d], ecnt);
      end
      default: ph[d] = 0;
    endcase
    if (ph[d] == 0 && o_req[d] && i_valid[d]) begin
      if (expq[d].size() == 0) begin
        chk("exp_queue_empty", d, 32'd1, 32'd0);
      end else begin
        cur[d] = expq[d].pop_front();
        chk("fetch_addr", d, o_addr[d], cur[d].pc);
        ph[d] = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  // Wait (bounded) until DUT d is requesting; called at posedge+1.
  task automatic wait_req(input int d, output bit ok);
    int n;
    n = 0;
    while (!o_req[d] && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    ok = o_req[d];
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL fetch_timeout dut%0d: imem_req still 0 after %0d cycles", d, n);
    end
  endtask

  // Serve one fetch with w wait states, then hand over ins with zero flag z.
  task automatic run_instr(input int d, input logic [15:0] ins, input int w, input logic z);
    bit ok;
    wait_req(d, ok);
    if (!ok) return;
    for (int k = 0; k < w; k++) begin
      i_rdata[d] = 16'($urandom);
      @(posedge clk); #1;
    end
    expq[d].push_back(model(m_pc[d], (d == 0) ? 16 : 4, ins, z));
    m_pc[d]    = longint'(expq[d][expq[d].size() - 1].next);
    i_valid[d] = 1'b1;
    i_rdata[d] = ins;
    i_zero[d]  = z;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      i_valid[d] = 1'($urandom);
      i_rdata[d] = 16'($urandom);
    end
    @(posedge clk); #1;
    i_valid[d] = 1'b0;
  endtask

  task automatic run_random(input int d, input int n);
    logic [3:0] op;
    for (int k = 0; k < n; k++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd10) op = 4'd11;
      run_instr(d, {op, 12'($urandom)}, $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    bit ok;
    nchk = 0;
    nerr = 0;
    for (int d = 0; d < 2; d++) begin
      rst_v[d]   = 1'b0;
      i_valid[d] = 1'b0;
      i_rdata[d] = 16'd0;
      i_zero[d]  = 1'b0;
      m_pc[d]    = 0;
      ph[d]      = 0;
      rel[d]     = 0;
      nret[d]    = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_v[0] = 1'b1;

    // Directed sequence on the 16-bit PC core.
    run_instr(0, 16'h0650, 2, 1'b0);   // ADD r3,r1,r2 with two wait states
    run_instr(0, 16'h9005, 0, 1'b0);   // JMP 5
    run_instr(0, 16'h803E, 1, 1'b1);   // BEQ -2 taken: 5 -> 4
    run_instr(0, 16'hB000, 0, 1'b0);   // NOP: 4 -> 5
    run_instr(0, 16'h803E, 0, 1'b0);   // BEQ -2 not taken: 5 -> 6
    run_random(0, 50);

    // Reset in the middle of a fetch, with a late valid during reset.
    wait_req(0, ok);
    i_valid[0] = 1'b0;
    #2;
    rst_v[0] = 1'b0;
    expq[0].delete();
    m_pc[0] = 0;
    @(posedge clk); #1;
    i_valid[0] = 1'b1;
    i_rdata[0] = 16'h0650;
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    i_valid[0] = 1'b0;
    run_random(0, 10);
    run_instr(0, 16'hA000, 1, 1'b0);   // HALT
    repeat (22) @(posedge clk);
    #1;

    // 4-bit PC core: wrap and truncation cases.
    rst_v[1] = 1'b1;
    run_instr(1, 16'h900F, 0, 1'b0);   // JMP 15
    run_instr(1, 16'h0650, 1, 1'b0);   // ADD at 15 -> wraps to 0
    run_instr(1, 16'h9123, 0, 1'b0);   // JMP 0x123 -> 3
    run_instr(1, 16'h8002, 0, 1'b1);   // BEQ +2 taken: 3 -> 6
    run_random(1, 40);
    run_instr(1, 16'hA000, 2, 1'b0);   // HALT
    repeat (22) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/risc_ctrl_seq.md
# risc_ctrl_seq

Parametrised multi-cycle control sequencer for the RISC core, succeeding the fixed 8-bit control unit. It runs a FETCH/DECODE/EXEC/WB state machine with a program counter of configurable width. It fetches from instruction memory over a request/valid handshake that tolerates wait states, and drives register-file and ALU control to an external datapath. It supports conditional branches, jumps and halt.

## Interface
- `AW`, 16: program counter and instruction address width (4..32).
- `RESET_PC`, 0: PC value loaded on reset (AW bits).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out AW: fetch address, always equal to `pc_out`.
- `imem_rdata` in 16: instruction word.
- `imem_valid` in 1: `imem_rdata` is valid this cycle.
- `alu_zero` in 1: ALU result is zero (datapath).
- `pc_out` out AW: current PC.
- `alu_op` out 3: ALU operation.
- `rf_raddr1`, `rf_raddr2` out 3: register read addresses.
- `rf_waddr` out 3: register write address.
- `rf_we` out 1: register write enable.
- `halted` out 1: core halted.
- `instr_count` out 32: retired-instruction count (see Configuration).

## Operation
- Instruction fields: `[15:12]` opcode, `[11:9]` rd, `[8:6]` rs1, `[5:3]` rs2, `[5:0]` imm6 (signed), `[11:0]` imm12 (unsigned).
- Opcodes 0–7: ALU register op. `alu_op` = opcode[2:0]; rd ← rs1 op rs2.
- Opcode 8, BEQ: `alu_op` = 1 (SUB) on rs1, rs2. Taken if `alu_zero`=1.
- Opcode 9, JMP: PC ← zero-extended imm12, truncated to AW bits.
- Opcode 10, HALT.
- Opcodes 11–15: NOP.
- PC is word-addressed. All PC arithmetic wraps modulo 2^AW.
- States:
  - IDLE → FETCH unconditionally.
  - FETCH: `imem_req`=1. Stays until `imem_valid`=1, then latches `imem_rdata` and goes to DECODE.
  - DECODE: registers `rf_raddr1`/`rf_raddr2` from rs1/rs2 and `rf_waddr` from rd → EXEC.
  - EXEC: drives `alu_op` (opcodes 0–8; otherwise 0). Samples `alu_zero` at end of cycle → WB.
  - WB:
    - `rf_we`=1 for opcodes 0–7.
    - PC update: BEQ taken → PC+1+sext(imm6); JMP → imm12; all others → PC+1.
    - Next state: HALT for opcode 10 (PC unchanged), else FETCH.
  - HALT: `halted`=1. All control outputs 0. Terminal until reset.
- `imem_valid` outside FETCH is ignored. `imem_rdata` is sampled only on the accepting edge.
- Reset assertion at any time, including mid-fetch with a request outstanding, aborts immediately. State returns to IDLE; no instruction is retired.

## Timing
- Reset values:
  - state IDLE, `pc_out`=RESET_PC, `halted`=0, `instr_count`=0.
  - `imem_req`, `alu_op`, `rf_raddr1`, `rf_raddr2`, `rf_waddr`, `rf_we` all 0.
- First `imem_req` is asserted in the second cycle after `rst_n` deasserts.
- `imem_req`, `alu_op`, `rf_we` and `halted` decode from registered state; no combinational path from inputs to outputs.
- Instruction latency = 4 + W cycles, where W = cycles in FETCH with `imem_valid`=0.
- New `pc_out` is visible in the first FETCH cycle of the next instruction.
- `rf_we` is a single-cycle pulse per ALU instruction.

## Configuration
- `RISC_CTRL_PERF_EN` defined: `instr_count` increments by 1 on every WB cycle, HALT included. It wraps at 2^32 and is cleared only by reset.
- `RISC_CTRL_PERF_EN` undefined: `instr_count` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset → all outputs match reset values. `imem_req` rises exactly 2 cycles after `rst_n` rises; `imem_addr`=RESET_PC.
- ADD r3,r1,r2 (0x0650) with `imem_valid` delayed 2 cycles:
  - `rf_raddr1`=1, `rf_raddr2`=2, `alu_op`=0 in EXEC.
  - `rf_we`=1 with `rf_waddr`=3 in WB.
  - Next fetch at PC+1, 6 cycles after the first `imem_req`.
- BEQ at PC 5 with imm6=0x3E (−2):
  - `alu_zero`=1 → next PC 4.
  - `alu_zero`=0 → next PC 6.
  - `rf_we` stays 0 in both cases.
- AW=4, non-branch at PC 15 → next PC 0. JMP 0x0123 with AW=4 → PC 3.
- HALT (0xA000):
  - `halted`=1 from the cycle after WB; `imem_req` stays 0 for 20 cycles.
  - `instr_count` = retired count including the HALT with `RISC_CTRL_PERF_EN` defined, and 0 without it.
- Assert `rst_n` low during FETCH with `imem_valid` pending → outputs return to reset values asynchronously and the late `imem_valid` is ignored.
